// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// The state encoding is fixed at two bits with IDLE at zero.
package mul_pkg;

   localparam int MUL_W     = 16;
   localparam int MUL_STEPS = 16;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mul_state_t;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequential 16-step shift-and-add multiplier with one-cycle sign fix-up.
// The result is held on res_lo/res_hi and written once to an external product register.
module mul_seq_ctrl
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sgn,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             mulreg_we,
   output logic [WIDTH-1:0] mulreg_d
);

   mul_state_t         state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [2*WIDTH-1:0] res_q, res_d;

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;

   // Two's-complement magnitude; the most negative value maps onto itself,
   // which is still the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             is_signed);
      return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
   endfunction

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_hi_d = acc_hi_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      res_d    = res_q;
      sum      = '0;
      prod     = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = magnitude(a, sgn);
               mplier_d = magnitude(b, sgn);
               neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_hi_d = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end

         RUN: begin
            // The multiplier register shifts out consumed bits and fills with product bits.
            sum = {1'b0, acc_hi_q} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
            {acc_hi_d, mplier_d} = {sum, mplier_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            prod = {acc_hi_q, mplier_q};
            if (neg_q) begin
               prod = ~prod + (2*WIDTH)'(1);
            end
            res_d   = prod;
            state_d = DONE;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The whole datapath is reset, not just the control state, so the held
   // result reads zero after reset and an aborted operation leaves no residue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_hi_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         res_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_hi_q <= acc_hi_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         res_q    <= res_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign mulreg_we = done;
   assign res_lo    = res_q[WIDTH-1:0];
   assign res_hi    = res_q[2*WIDTH-1:WIDTH];
   assign mulreg_d  = res_lo;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl with hand-computed products.
// Each scenario task drives its own stimulus and compares outputs inline.
module tb_mul_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        sgn;
   logic        busy;
   logic        done;
   logic [15:0] res_lo;
   logic [15:0] res_hi;
   logic        mulreg_we;
   logic [15:0] mulreg_d;

   int checks = 0;
   int errors = 0;

   mul_seq_ctrl #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .sgn       (sgn),
      .busy      (busy),
      .done      (done),
      .res_lo    (res_lo),
      .res_hi    (res_hi),
      .mulreg_we (mulreg_we),
      .mulreg_d  (mulreg_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation from IDLE and returns in the cycle done is first seen
   // (or after a bounded wait). mid_ok tracks busy high, no write, and held results
   // in every cycle between the start cycle and done.
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic isgn,
                        output int lat, output bit mid_ok);
      logic [15:0] lo0;
      logic [15:0] hi0;
      lo0    = res_lo;
      hi0    = res_hi;
      a      = ia;
      b      = ib;
      sgn    = isgn;
      start  = 1'b1;
      mid_ok = 1'b1;
      step();
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
      sgn   = 1'($urandom);
      lat   = 1;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1 || mulreg_we !== 1'b0 || res_lo !== lo0 || res_hi !== hi0)
            mid_ok = 1'b0;
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      start = 1'b0;
      a     = 16'h0;
      b     = 16'h0;
      sgn   = 1'b0;
      #3;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (mulreg_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mulreg_we); end
      checks++; if (res_lo !== 16'h0) begin errors++; $display("FAIL reset_res_lo: got %h want 0000", res_lo); end
      checks++; if (res_hi !== 16'h0) begin errors++; $display("FAIL reset_res_hi: got %h want 0000", res_hi); end
      checks++; if (mulreg_d !== 16'h0) begin errors++; $display("FAIL reset_mulreg_d: got %h want 0000", mulreg_d); end
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_unsigned();
      int lat;
      bit mid_ok;
      do_op(16'hFFFF, 16'hFFFF, 1'b0, lat, mid_ok);
      checks++; if (lat != 18) begin errors++; $display("FAIL u_ffff_latency: got %0d want 18", lat); end
      checks++; if (mid_ok !== 1'b1) begin errors++; $display("FAIL u_ffff_midop: got %b want 1", mid_ok); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL u_ffff_done: got %b want 1", done); end
      checks++; if (mulreg_we !== 1'b1) begin errors++; $display("FAIL u_ffff_we: got %b want 1", mulreg_we); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL u_ffff_busy_done: got %b want 1", busy); end
      checks++; if (res_hi !== 16'hFFFE) begin errors++; $display("FAIL u_ffff_hi: got %h want fffe", res_hi); end
      checks++; if (res_lo !== 16'h0001) begin errors++; $display("FAIL u_ffff_lo: got %h want 0001", res_lo); end
      checks++; if (mulreg_d !== 16'h0001) begin errors++; $display("FAIL u_ffff_d: got %h want 0001", mulreg_d); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL u_ffff_busy_idle: got %b want 0", busy); end
      checks++; if (done !== 1'b0 || mulreg_we !== 1'b0) begin errors++; $display("FAIL u_ffff_pulse_end: got done=%b we=%b want 0 0", done, mulreg_we); end
      checks++; if ({res_hi, res_lo} !== 32'hFFFE_0001) begin errors++; $display("FAIL u_ffff_hold: got %h want fffe0001", {res_hi, res_lo}); end
   endtask

   task automatic test_signed();
      int lat;
      bit mid_ok;
      do_op(16'hFFFD, 16'h0005, 1'b1, lat, mid_ok);
      checks++; if (lat != 18) begin errors++; $display("FAIL s_m3x5_latency: got %0d want 18", lat); end
      checks++; if ({res_hi, res_lo} !== 32'hFFFF_FFF1) begin errors++; $display("FAIL s_m3x5_res: got %h want fffffff1", {res_hi, res_lo}); end
      step();
      do_op(16'h8000, 16'h8000, 1'b1, lat, mid_ok);
      checks++; if (lat != 18) begin errors++; $display("FAIL s_8000_latency: got %0d want 18", lat); end
      checks++; if ({res_hi, res_lo} !== 32'h4000_0000) begin errors++; $display("FAIL s_8000_res: got %h want 40000000", {res_hi, res_lo}); end
      step();
      do_op(16'h0007, 16'hFFFE, 1'b1, lat, mid_ok);
      checks++; if ({res_hi, res_lo} !== 32'hFFFF_FFF2) begin errors++; $display("FAIL s_7xm2_res: got %h want fffffff2", {res_hi, res_lo}); end
      step();
   endtask

   task automatic test_zero_sign();
      int lat;
      bit mid_ok;
      do_op(16'h0000, 16'hFFFB, 1'b1, lat, mid_ok);
      checks++; if ({res_hi, res_lo} !== 32'h0000_0000) begin errors++; $display("FAIL s_zero_res: got %h want 00000000", {res_hi, res_lo}); end
      checks++; if (mulreg_d !== 16'h0000) begin errors++; $display("FAIL s_zero_d: got %h want 0000", mulreg_d); end
      step();
      do_op(16'h1234, 16'h0001, 1'b0, lat, mid_ok);
      checks++; if (res_hi !== 16'h0000) begin errors++; $display("FAIL u_ident_hi: got %h want 0000", res_hi); end
      checks++; if (res_lo !== 16'h1234) begin errors++; $display("FAIL u_ident_lo: got %h want 1234", res_lo); end
      step();
      do_op(16'hFFFB, 16'h0003, 1'b0, lat, mid_ok);
      checks++; if ({res_hi, res_lo} !== 32'h0002_FFF1) begin errors++; $display("FAIL u_fffb_res: got %h want 0002fff1", {res_hi, res_lo}); end
      step();
   endtask

   task automatic test_start_held();
      logic [15:0] op_a [3];
      logic [15:0] op_b [3];
      logic        op_s [3];
      logic [31:0] op_p [3];
      op_a[0] = 16'h0003; op_b[0] = 16'h0007; op_s[0] = 1'b0; op_p[0] = 32'h0000_0015;
      op_a[1] = 16'hFFFF; op_b[1] = 16'hFFFF; op_s[1] = 1'b1; op_p[1] = 32'h0000_0001;
      op_a[2] = 16'h0100; op_b[2] = 16'h0100; op_s[2] = 1'b0; op_p[2] = 32'h0001_0000;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a   = op_a[i];
         b   = op_b[i];
         sgn = op_s[i];
         for (int k = 1; k <= 18; k++) begin
            step();
            if (k < 18) begin
               checks++;
               if (busy !== 1'b1 || done !== 1'b0) begin
                  errors++;
                  $display("FAIL held_mid_op%0d_c%0d: got busy=%b done=%b want 1 0", i, k, busy, done);
               end
               a   = 16'($urandom);
               b   = 16'($urandom);
               sgn = 1'($urandom);
            end
         end
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL held_done_op%0d: got %b want 1", i, done); end
         checks++; if ({res_hi, res_lo} !== op_p[i]) begin errors++; $display("FAIL held_res_op%0d: got %h want %h", i, {res_hi, res_lo}, op_p[i]); end
         step();
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_op%0d: got busy=%b want 0", i, busy); end
      end
      start = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      int lat;
      bit mid_ok;
      bit saw_done;
      a        = 16'h1234;
      b        = 16'h5678;
      sgn      = 1'b0;
      start    = 1'b1;
      saw_done = 1'b0;
      step();
      start = 1'b0;
      for (int k = 1; k < 9; k++) begin
         if (done !== 1'b0 || mulreg_we !== 1'b0) saw_done = 1'b1;
         step();
      end
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
      checks++; if ({res_hi, res_lo, mulreg_d} !== 48'h0) begin errors++; $display("FAIL rmid_res: got %h want 0", {res_hi, res_lo, mulreg_d}); end
      for (int k = 0; k < 3; k++) begin
         step();
         if (done !== 1'b0 || mulreg_we !== 1'b0) saw_done = 1'b1;
      end
      rst = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (done !== 1'b0 || mulreg_we !== 1'b0) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse: got pulse=%b want 0", saw_done); end
      do_op(16'h0003, 16'h0007, 1'b0, lat, mid_ok);
      checks++; if (lat != 18) begin errors++; $display("FAIL rmid_fresh_latency: got %0d want 18", lat); end
      checks++; if ({res_hi, res_lo} !== 32'h0000_0015) begin errors++; $display("FAIL rmid_fresh_res: got %h want 00000015", {res_hi, res_lo}); end
      step();
   endtask

   task automatic test_back_to_back();
      int lat;
      bit mid_ok;
      do_op(16'h0002, 16'h0003, 1'b0, lat, mid_ok);
      checks++; if (res_lo !== 16'h0006) begin errors++; $display("FAIL b2b_first_lo: got %h want 0006", res_lo); end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_first_one_cycle: got %b want 0", done); end
      do_op(16'h0004, 16'h0005, 1'b0, lat, mid_ok);
      checks++; if (mid_ok !== 1'b1) begin errors++; $display("FAIL b2b_hold_between: got %b want 1", mid_ok); end
      checks++; if (lat != 18) begin errors++; $display("FAIL b2b_second_latency: got %0d want 18", lat); end
      checks++; if (res_lo !== 16'h0014) begin errors++; $display("FAIL b2b_second_lo: got %h want 0014", res_lo); end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_second_one_cycle: got %b want 0", done); end
      checks++; if (res_lo !== 16'h0014) begin errors++; $display("FAIL b2b_second_hold: got %h want 0014", res_lo); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_zero_sign();
      test_start_held();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential shift-and-add multiplier controller for the 16-bit datapath. It accepts a multiply request with two 16-bit operands and sequences a 16-step unsigned shift-add. In signed mode it applies sign correction in one extra cycle. On completion it issues a one-cycle write into the 16-bit product register (low half) and holds the full 32-bit result on its outputs until the next operation completes.

## Interface
- WIDTH, 16, operand width; result is 2*WIDTH; only 16 is verified
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- a  in  16  multiplicand, sampled with start
- b  in  16  multiplier, sampled with start
- sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- busy  out  1  high in RUN, FIX, DONE
- done  out  1  one-cycle pulse in DONE
- res_lo  out  16  product bits [15:0], held
- res_hi  out  16  product bits [31:16], held
- mulreg_we  out  1  product-register write enable; equals done
- mulreg_d  out  16  product-register write data; equals res_lo

## Operation
- States: IDLE, RUN, FIX, DONE; 2-bit encoding, IDLE = 0.
- IDLE, start=1:
  - mcand <= |a| if sgn else a; mplier <= |b| if sgn else b.
  - neg <= sgn & (a[15] ^ b[15]); acc_hi <= 0; cnt <= 0; go RUN.
  - |0x8000| = 0x8000 as a 16-bit unsigned magnitude.
- IDLE, start=0: stay; all registers hold.
- RUN, each cycle:
  - sum[16:0] = acc_hi + (mplier[0] ? mcand : 0).
  - {acc_hi, mplier} <= {sum, mplier[15:1]}, a 33-bit shift right by 1; mplier becomes the low product half.
  - cnt <= cnt + 1; on cnt == 15, go FIX.
- FIX:
  - p = {acc_hi, mplier}; if neg, p = ~p + 1 (mod 2^32).
  - {res_hi, res_lo} <= p; go DONE.
- DONE: done=1, mulreg_we=1; go IDLE unconditionally.
- start is ignored in RUN/FIX/DONE. No queueing, no error flag.
- a, b, sgn may change freely after the sampling edge.
- Reset assertion at any time: state IDLE; all outputs 0; in-flight operation discarded; no mulreg_we pulse.

## Timing
- start high in cycle N (IDLE) → RUN in cycles N+1..N+16 → FIX in N+17 → DONE in N+18.
- done, mulreg_we, and the new res_lo/res_hi are valid in cycle N+18; latency is fixed at 18 cycles.
- busy is high in N+1..N+18 and low in N+19 (IDLE).
- Earliest next start is cycle N+19, giving a throughput of one result per 19 cycles.
- res_lo/res_hi change only on the FIX→DONE edge and hold otherwise, including across IDLE.
- Reset values: busy=0, done=0, mulreg_we=0, res_lo=0, res_hi=0, mulreg_d=0.
- All outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.

## Structure
- Package mul_pkg:
  - typedef mul_state_t {IDLE, RUN, FIX, DONE}
  - MUL_W = 16; MUL_STEPS = 16; CNT_W = 4.
- Single module; no sub-module.
- The product register is external and driven by mulreg_we/mulreg_d.

## Test plan
- Unsigned 0xFFFF × 0xFFFF, sgn=0 → at N+18: res_hi=0xFFFE, res_lo=0x0001, done=1, mulreg_we=1, mulreg_d=0x0001.
- Signed 0xFFFD × 0x0005 (−3×5), sgn=1 → res_hi=0xFFFF, res_lo=0xFFF1. Signed 0x8000 × 0x8000 → res_hi=0x4000, res_lo=0x0000.
- Zero and sign:
  - signed 0x0000 × 0xFFFB → 0x0000_0000, with neg set internally.
  - unsigned 0x1234 × 0x0001 → res_hi=0x0000, res_lo=0x1234.
- start held high continuously, operands changed every cycle:
  - exactly one operation per 19 cycles; results match operands sampled at each IDLE cycle.
  - busy never deasserts mid-operation.
- rst low in cycle N+9 of an operation → outputs 0 immediately, no done/mulreg_we pulse; a fresh 3×7 after release → res_lo=0x0015 at latency 18.
- Back-to-back 2×3 then 4×5 → res_lo=0x0006 held from done#1 until done#2, then 0x0014; done is high exactly one cycle each.
